// File: rtl/barrier_token_rx.sv
// barrier_token_rx: receive side of the TCP barrier.
// Decodes barrier token frames from the TCP rx stream, keeps a saturating
// 2-bit arrival count per epoch and releases each local epoch wait once per
// received token.
// Optional statistics (good/bad counts, last sender/session) are built when
// the macro BARRIER_RX_STAT_EN is defined.
module barrier_token_rx #(
    parameter int unsigned MAX_EPOCH = 8,
    parameter logic [31:0] MAGIC     = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_axis_rx_metadata_valid,
    output logic              s_axis_rx_metadata_ready,
    input  logic [15:0]       s_axis_rx_metadata_data,
    input  logic              s_axis_rx_data_valid,
    output logic              s_axis_rx_data_ready,
    input  logic [511:0]      s_axis_rx_data_data,
    input  logic [63:0]       s_axis_rx_data_keep,
    input  logic              s_axis_rx_data_last,
    input  logic              clear_all,
    input  logic              wait_valid,
    input  logic [7:0]        wait_epoch,
    output logic              wait_done,
    output logic [7:0][31:0]  status_reg
);

    localparam int unsigned CNT_W       = 2;
    localparam logic [7:0]  MAX_EPOCH_B = 8'(MAX_EPOCH);
    localparam logic [1:0]  CNT_MAX     = 2'd3;

    typedef enum logic {ST_HEAD, ST_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [MAX_EPOCH];
    logic [CNT_W-1:0]   cnt_d [MAX_EPOCH];
    logic               ovf_q, ovf_d;
    logic [31:0]        st0_q, st0_d;
    logic [31:0]        st1_q, st1_d;

    logic               rx_beat;
    logic               head_beat;
    logic [7:0]         head_epoch;
    logic [7:0]         head_sender;
    logic               good_tok;
    logic               bad_tok;
    logic               wait_hit;
    logic               wait_fire;

    // Payload bits beyond the token header are never inspected.
    logic               unused_bits;
    assign unused_bits = ^{s_axis_rx_data_keep, s_axis_rx_data_data[511:48], bad_tok};

    // Head-beat decode: only the first beat of a frame carries a token.
    assign rx_beat     = s_axis_rx_data_valid & s_axis_rx_data_ready;
    assign head_beat   = rx_beat & (state_q == ST_HEAD);
    assign head_epoch  = s_axis_rx_data_data[39:32];
    assign head_sender = s_axis_rx_data_data[47:40];
    assign good_tok    = head_beat & (s_axis_rx_data_data[31:0] == MAGIC)
                       & (head_epoch < MAX_EPOCH_B);
    assign bad_tok     = head_beat & ~good_tok;

    // Frame tracker next state: drain the tail of multi-beat frames.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HEAD:  if (rx_beat && !s_axis_rx_data_last) state_d = ST_DRAIN;
            ST_DRAIN: if (rx_beat &&  s_axis_rx_data_last) state_d = ST_HEAD;
            default:  state_d = ST_HEAD;
        endcase
    end

    // Wait qualifies when its epoch is tracked and has a buffered token.
    always_comb begin
        wait_hit = 1'b0;
        for (int i = 0; i < int'(MAX_EPOCH); i++) begin
            if (wait_epoch == 8'(i) && cnt_q[i] != '0) wait_hit = 1'b1;
        end
    end

    assign wait_fire = wait_valid & wait_hit & ~wait_done;

    // Counter next state: saturating increment, decrement on consume, clear wins.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < int'(MAX_EPOCH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (good_tok && head_epoch == 8'(i) && !(wait_fire && wait_epoch == 8'(i))) begin
                if (cnt_q[i] == CNT_MAX) ovf_d = 1'b1;
                else                     cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (wait_fire && wait_epoch == 8'(i) && !(good_tok && head_epoch == 8'(i))) begin
                cnt_d[i] = cnt_q[i] - 2'd1;
            end
        end
        if (clear_all) begin
            for (int i = 0; i < int'(MAX_EPOCH); i++) cnt_d[i] = '0;
            ovf_d = 1'b0;
        end
    end

    // Status words built from next-state values so they track the counters.
    always_comb begin
        st0_d = '0;
        st1_d = '0;
        for (int i = 0; i < int'(MAX_EPOCH); i++) begin
            st0_d[i]          = (cnt_d[i] != '0);
            st1_d[2*i +: 2]   = cnt_d[i];
        end
        st0_d[31] = ovf_d;
    end

    // Core state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                  <= ST_HEAD;
            ovf_q                    <= 1'b0;
            wait_done                <= 1'b0;
            s_axis_rx_metadata_ready <= 1'b1;
            s_axis_rx_data_ready     <= 1'b1;
            st0_q                    <= '0;
            st1_q                    <= '0;
            for (int i = 0; i < int'(MAX_EPOCH); i++) cnt_q[i] <= '0;
        end else begin
            state_q                  <= state_d;
            ovf_q                    <= ovf_d;
            wait_done                <= wait_fire;
            s_axis_rx_metadata_ready <= 1'b1;
            s_axis_rx_data_ready     <= 1'b1;
            st0_q                    <= st0_d;
            st1_q                    <= st1_d;
            for (int i = 0; i < int'(MAX_EPOCH); i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef BARRIER_RX_STAT_EN
    logic [15:0] sess_id_q;
    logic [31:0] good_cnt_q;
    logic [31:0] bad_cnt_q;
    logic [31:0] info_q;

    // Statistics: cleared only by reset, never by clear_all.
    always_ff @(posedge clk) begin
        if (rst) begin
            sess_id_q  <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            info_q     <= '0;
        end else begin
            if (s_axis_rx_metadata_valid) sess_id_q <= s_axis_rx_metadata_data;
            if (good_tok) begin
                good_cnt_q <= good_cnt_q + 32'd1;
                info_q     <= {8'h00, head_sender, sess_id_q};
            end
            if (bad_tok) bad_cnt_q <= bad_cnt_q + 32'd1;
        end
    end
`else
    // Session id only feeds the statistics block.
    logic unused_meta;
    assign unused_meta = ^{s_axis_rx_metadata_valid, s_axis_rx_metadata_data, head_sender};
`endif

    // Status word array assembly.
    always_comb begin
        status_reg    = '0;
        status_reg[0] = st0_q;
        status_reg[1] = st1_q;
`ifdef BARRIER_RX_STAT_EN
        status_reg[2] = good_cnt_q;
        status_reg[3] = bad_cnt_q;
        status_reg[4] = info_q;
`endif
    end

endmodule

// File: tb/tb_barrier_token_rx.sv
// Self-checking bench for barrier_token_rx: token decode, early tokens,
// bad/multi-beat frames, overflow and clear, collisions, reset mid-frame.
module tb_barrier_token_rx;

    localparam logic [31:0] MAGIC = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic              meta_valid;
    logic              meta_ready;
    logic [15:0]       meta_data;
    logic              data_valid;
    logic              data_ready;
    logic [511:0]      data_data;
    logic [63:0]       data_keep;
    logic              data_last;
    logic              clear_all;
    logic              wait_valid;
    logic [7:0]        wait_epoch;
    logic              wait_done;
    logic [7:0][31:0]  status_reg;

    int checks   = 0;
    int failures = 0;

    int          model_cnt [8];
    bit          model_ovf;
    int unsigned model_good;
    int unsigned model_bad;
    logic [15:0] model_sess;
    logic [7:0]  model_sender;

    typedef struct {
        int epoch;
        int cnt_after;
    } wexp_t;
    wexp_t sb[$];

    barrier_token_rx dut (
        .clk                      (clk),
        .rst                      (rst),
        .s_axis_rx_metadata_valid (meta_valid),
        .s_axis_rx_metadata_ready (meta_ready),
        .s_axis_rx_metadata_data  (meta_data),
        .s_axis_rx_data_valid     (data_valid),
        .s_axis_rx_data_ready     (data_ready),
        .s_axis_rx_data_data      (data_data),
        .s_axis_rx_data_keep      (data_keep),
        .s_axis_rx_data_last      (data_last),
        .clear_all                (clear_all),
        .wait_valid               (wait_valid),
        .wait_epoch               (wait_epoch),
        .wait_done                (wait_done),
        .status_reg               (status_reg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_st0();
        logic [31:0] v = '0;
        for (int i = 0; i < 8; i++) if (model_cnt[i] != 0) v[i] = 1'b1;
        v[31] = model_ovf;
        return v;
    endfunction

    function automatic logic [31:0] exp_st1();
        logic [31:0] v = '0;
        for (int i = 0; i < 8; i++) v[2*i +: 2] = 2'(model_cnt[i]);
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model_cnt[i] = 0;
        model_ovf = 1'b0;
    endtask

    task automatic model_token(input logic [31:0] magic, input logic [7:0] ep, input logic [7:0] snd);
        if (magic == MAGIC && ep < 8'd8) begin
            model_good++;
            model_sender = snd;
            if (model_cnt[ep] == 3) model_ovf = 1'b1;
            else model_cnt[ep]++;
        end else begin
            model_bad++;
        end
    endtask

    task automatic send_meta(input logic [15:0] sess);
        @(negedge clk);
        meta_valid = 1'b1;
        meta_data  = sess;
        @(negedge clk);
        meta_valid = 1'b0;
        model_sess = sess;
    endtask

    // Drive one frame; beat 1 optionally carries a decoy MAGIC header.
    task automatic send_frame(input logic [31:0] magic, input logic [7:0] ep,
                              input logic [7:0] snd, input int nbeats, input bit decoy);
        logic [511:0] d;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom();
            if (b == 0) begin
                d[31:0]  = magic;
                d[39:32] = ep;
                d[47:40] = snd;
            end else if (b == 1 && decoy) begin
                d[31:0]  = MAGIC;
                d[39:32] = 8'd5;
            end else begin
                d[31:0]  = 32'h0BAD_0000 | 32'(b);
            end
            data_valid = 1'b1;
            data_data  = d;
            data_last  = (b == nbeats - 1);
        end
        @(negedge clk);
        data_valid = 1'b0;
        data_last  = 1'b0;
        model_token(magic, ep, snd);
    endtask

    // Issue a wait; expected completions go through the scoreboard.
    task automatic do_wait(input int ep, input bit expect_done);
        bit got = 1'b0;
        int lat = 0;
        wexp_t e;
        if (expect_done) begin
            model_cnt[ep]--;
            sb.push_back('{epoch: ep, cnt_after: model_cnt[ep]});
        end
        @(negedge clk);
        wait_valid = 1'b1;
        wait_epoch = 8'(ep);
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (wait_done) begin
                got = 1'b1;
                lat = c;
                wait_valid = 1'b0;
            end
        end
        wait_valid = 1'b0;
        if (expect_done) begin
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL wait_timeout epoch=%0d: wait_done never seen, required within 8 cycles", ep);
                void'(sb.pop_front());
            end else begin
                e = sb.pop_front();
                if (lat != 1) begin
                    failures++;
                    $display("FAIL wait_latency epoch=%0d: got %0d cycles, required 1", e.epoch, lat);
                end
                checks++;
                if (status_reg[1][2*e.epoch +: 2] !== 2'(e.cnt_after)) begin
                    failures++;
                    $display("FAIL wait_cnt epoch=%0d: got %0d, required %0d",
                             e.epoch, status_reg[1][2*e.epoch +: 2], e.cnt_after);
                end
                @(negedge clk);
                checks++;
                if (wait_done !== 1'b0) begin
                    failures++;
                    $display("FAIL wait_pulse epoch=%0d: wait_done=%b, required 0", e.epoch, wait_done);
                end
            end
        end else begin
            checks++;
            if (got) begin
                failures++;
                $display("FAIL wait_ignored epoch=%0d: wait_done seen, required never", ep);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (wait_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_wait_done: got %b, required 0", wait_done);
        end
        checks++;
        if (meta_ready !== 1'b1 || data_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: meta=%b data=%b, required 1 1", meta_ready, data_ready);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (status_reg[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset_status[%0d]: got %h, required 0", k, status_reg[k]);
            end
        end
    endtask

    task automatic test_single_token();
        send_meta(16'hABCD);
        send_frame(MAGIC, 8'd0, 8'd1, 1, 1'b0);
        checks++;
        if (status_reg[0] !== 32'h1) begin
            failures++;
            $display("FAIL single_pending: got %h, required 00000001", status_reg[0]);
        end
`ifdef BARRIER_RX_STAT_EN
        checks++;
        if (status_reg[2] !== 32'(model_good)) begin
            failures++;
            $display("FAIL single_good_cnt: got %0d, required %0d", status_reg[2], model_good);
        end
        checks++;
        if (status_reg[4] !== {8'h00, model_sender, model_sess}) begin
            failures++;
            $display("FAIL single_info: got %h, required %h", status_reg[4], {8'h00, model_sender, model_sess});
        end
`else
        checks++;
        if (status_reg[2] !== 32'h0 || status_reg[4] !== 32'h0) begin
            failures++;
            $display("FAIL single_stat_tied: got %h %h, required 0 0", status_reg[2], status_reg[4]);
        end
`endif
        do_wait(0, 1'b1);
        checks++;
        if (status_reg[0] !== 32'h0) begin
            failures++;
            $display("FAIL single_after_wait: got %h, required 0", status_reg[0]);
        end
    endtask

    task automatic test_early_token();
        send_frame(MAGIC, 8'd2, 8'd3, 1, 1'b0);
        send_frame(MAGIC, 8'd1, 8'd4, 1, 1'b0);
        checks++;
        if (status_reg[0] !== 32'h6) begin
            failures++;
            $display("FAIL early_bitmap: got %h, required 00000006", status_reg[0]);
        end
        checks++;
        if (status_reg[1] !== exp_st1()) begin
            failures++;
            $display("FAIL early_cnts: got %h, required %h", status_reg[1], exp_st1());
        end
        do_wait(1, 1'b1);
        do_wait(2, 1'b1);
        checks++;
        if (status_reg[0] !== 32'h0) begin
            failures++;
            $display("FAIL early_drained: got %h, required 0", status_reg[0]);
        end
    endtask

    task automatic test_bad_frames();
        send_frame(32'h0000_1234, 8'd0, 8'd2, 1, 1'b0);
        checks++;
        if (status_reg[0] !== exp_st0()) begin
            failures++;
            $display("FAIL bad_magic_bitmap: got %h, required %h", status_reg[0], exp_st0());
        end
        send_frame(MAGIC, 8'd4, 8'd3, 3, 1'b1);
        checks++;
        if (status_reg[1] !== 32'h0000_0100 || status_reg[0] !== 32'h10) begin
            failures++;
            $display("FAIL multibeat_head_only: got %h/%h, required 00000100/00000010", status_reg[1], status_reg[0]);
        end
        send_frame(MAGIC, 8'd9, 8'd3, 1, 1'b0);
        checks++;
        if (status_reg[0] !== exp_st0()) begin
            failures++;
            $display("FAIL bad_epoch_bitmap: got %h, required %h", status_reg[0], exp_st0());
        end
`ifdef BARRIER_RX_STAT_EN
        checks++;
        if (status_reg[3] !== 32'(model_bad) || status_reg[2] !== 32'(model_good)) begin
            failures++;
            $display("FAIL bad_stats: got good=%0d bad=%0d, required good=%0d bad=%0d",
                     status_reg[2], status_reg[3], model_good, model_bad);
        end
`endif
        do_wait(4, 1'b1);
        do_wait(9, 1'b0);
    endtask

    task automatic test_overflow();
        for (int n = 0; n < 4; n++) send_frame(MAGIC, 8'd3, 8'd2, 1, 1'b0);
        checks++;
        if (status_reg[0] !== 32'h8000_0008 || status_reg[0] !== exp_st0()) begin
            failures++;
            $display("FAIL ovf_status0: got %h, required 80000008", status_reg[0]);
        end
        checks++;
        if (status_reg[1] !== 32'hC0) begin
            failures++;
            $display("FAIL ovf_status1: got %h, required 000000c0", status_reg[1]);
        end
        @(negedge clk);
        clear_all = 1'b1;
        @(negedge clk);
        clear_all = 1'b0;
        model_clear();
        checks++;
        if (status_reg[0] !== 32'h0 || status_reg[1] !== 32'h0) begin
            failures++;
            $display("FAIL clear_all: got %h/%h, required 0/0", status_reg[0], status_reg[1]);
        end
    endtask

    task automatic test_collision();
        send_frame(MAGIC, 8'd0, 8'd7, 1, 1'b0);
        @(negedge clk);
        wait_valid = 1'b1;
        wait_epoch = 8'd0;
        data_valid = 1'b1;
        data_data  = '0;
        data_data[31:0]  = MAGIC;
        data_data[47:40] = 8'd7;
        data_last  = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        data_last  = 1'b0;
        model_good++;
        checks++;
        if (wait_done !== 1'b1) begin
            failures++;
            $display("FAIL collision_done: got %b, required 1", wait_done);
        end
        wait_valid = 1'b0;
        checks++;
        if (status_reg[1][1:0] !== 2'd1 || status_reg[0][31] !== 1'b0) begin
            failures++;
            $display("FAIL collision_cnt: cnt=%0d ovf=%b, required cnt=1 ovf=0",
                     status_reg[1][1:0], status_reg[0][31]);
        end
        @(negedge clk);
        checks++;
        if (wait_done !== 1'b0) begin
            failures++;
            $display("FAIL collision_pulse: got %b, required 0", wait_done);
        end
        do_wait(0, 1'b1);

        // Token arriving while a wait on an empty epoch is pending.
        @(negedge clk);
        wait_valid = 1'b1;
        wait_epoch = 8'd5;
        @(negedge clk);
        checks++;
        if (wait_done !== 1'b0) begin
            failures++;
            $display("FAIL empty_wait_early: got %b, required 0", wait_done);
        end
        data_valid = 1'b1;
        data_data  = '0;
        data_data[31:0]  = MAGIC;
        data_data[39:32] = 8'd5;
        data_last  = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        data_last  = 1'b0;
        model_good++;
        checks++;
        if (wait_done !== 1'b0 || status_reg[1][11:10] !== 2'd1) begin
            failures++;
            $display("FAIL late_token_arrive: done=%b cnt=%0d, required done=0 cnt=1",
                     wait_done, status_reg[1][11:10]);
        end
        @(negedge clk);
        checks++;
        if (wait_done !== 1'b1) begin
            failures++;
            $display("FAIL late_token_done: got %b, required 1", wait_done);
        end
        wait_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wait_done !== 1'b0 || status_reg[1] !== 32'h0) begin
            failures++;
            $display("FAIL late_token_drain: done=%b st1=%h, required 0 0", wait_done, status_reg[1]);
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        data_valid = 1'b1;
        data_data  = '0;
        data_data[31:0]  = MAGIC;
        data_data[39:32] = 8'd6;
        data_last  = 1'b0;
        @(negedge clk);
        data_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        model_good   = 0;
        model_bad    = 0;
        model_sess   = '0;
        model_sender = '0;
        checks++;
        if (wait_done !== 1'b0 || meta_ready !== 1'b1 || data_ready !== 1'b1 ||
            status_reg[0] !== 32'h0 || status_reg[1] !== 32'h0) begin
            failures++;
            $display("FAIL midframe_reset: done=%b rdy=%b%b st0=%h st1=%h, required 0 11 0 0",
                     wait_done, meta_ready, data_ready, status_reg[0], status_reg[1]);
        end
        data_valid = 1'b1;
        data_data  = '0;
        data_data[39:32] = 8'd6;
        data_last  = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        data_last  = 1'b0;
        model_bad++;
        checks++;
        if (status_reg[0] !== exp_st0() || status_reg[1] !== exp_st1()) begin
            failures++;
            $display("FAIL midframe_trailing: st0=%h st1=%h, required %h %h",
                     status_reg[0], status_reg[1], exp_st0(), exp_st1());
        end
`ifdef BARRIER_RX_STAT_EN
        checks++;
        if (status_reg[3] !== 32'(model_bad) || status_reg[2] !== 32'(model_good) || status_reg[4] !== 32'h0) begin
            failures++;
            $display("FAIL midframe_stats: good=%0d bad=%0d info=%h, required %0d %0d 0",
                     status_reg[2], status_reg[3], status_reg[4], model_good, model_bad);
        end
`endif
        for (int k = 5; k < 8; k++) begin
            checks++;
            if (status_reg[k] !== 32'h0) begin
                failures++;
                $display("FAIL status_tied[%0d]: got %h, required 0", k, status_reg[k]);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        meta_valid   = 1'b0;
        meta_data    = '0;
        data_valid   = 1'b0;
        data_data    = '0;
        data_keep    = '1;
        data_last    = 1'b0;
        clear_all    = 1'b0;
        wait_valid   = 1'b0;
        wait_epoch   = '0;
        model_ovf    = 1'b0;
        model_good   = 0;
        model_bad    = 0;
        model_sess   = '0;
        model_sender = '0;

        test_reset();
        test_single_token();
        test_early_token();
        test_bad_frames();
        test_overflow();
        test_collision();
        test_reset_midframe();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
